// File: rtl/scr1_rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
package scr1_rst_seq_pkg;

    localparam int SCR1_RST_SEQ_DOMAINS = 3;
    localparam int SCR1_RST_SEQ_HOLD    = 16;
    localparam int SCR1_RST_SEQ_GAP     = 4;
    localparam int SCR1_RST_SEQ_TIMEOUT = 256;

    typedef enum logic [2:0] {
        SCR1_RST_SEQ_IDLE,
        SCR1_RST_SEQ_ASSERT,
        SCR1_RST_SEQ_HOLD_ST,
        SCR1_RST_SEQ_RELEASE,
        SCR1_RST_SEQ_GAP_ST,
        SCR1_RST_SEQ_DONE,
        SCR1_RST_SEQ_ERROR
    } type_scr1_rst_seq_fsm_e;

    // Width needed to index n items, never below one bit
    function automatic int scr1_rst_seq_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scr1_rst_seq_cnt.sv
// Loadable saturating down-counter with zero flag.
module scr1_rst_seq_cnt #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scr1_reset_seq_ctrl.sv
// Ordered multi-domain reset sequencer; optional status watchdog
// enabled by SCR1_RST_SEQ_TIMEOUT_EN.
module scr1_reset_seq_ctrl
    import scr1_rst_seq_pkg::*;
#(
    parameter int DOMAINS        = SCR1_RST_SEQ_DOMAINS,
    parameter int HOLD_CYCLES    = SCR1_RST_SEQ_HOLD,
    parameter int GAP_CYCLES     = SCR1_RST_SEQ_GAP,
    parameter int TIMEOUT_CYCLES = SCR1_RST_SEQ_TIMEOUT,
    localparam int IDX_W         = scr1_rst_seq_idx_w(DOMAINS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_req,
    output logic               sw_rst_ready,
    input  logic [DOMAINS-1:0] rst_status_n,
    output logic [DOMAINS-1:0] rst_req_n,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               seq_err,
    output logic [IDX_W-1:0]   err_domain
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES + 1) ?
                             HOLD_CYCLES : GAP_CYCLES + 1;
    localparam int CNT_W   = scr1_rst_seq_idx_w(CNT_MAX);

    type_scr1_rst_seq_fsm_e state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DOMAINS-1:0] req_q, req_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               last;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;
    logic               tmo_zero;

    assign accept = sw_rst_req & rdy_q;
    assign last   = (idx_q == IDX_W'(DOMAINS - 1));

    // HOLD loads one less so that HOLD lasts exactly HOLD_CYCLES
    scr1_rst_seq_cnt #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(HOLD_CYCLES - 1))
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .val_i  (cnt_val),
        .dec_i  (1'b1),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCR1_RST_SEQ_HOLD_ST;
            idx_q   <= '0;
            req_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        req_d    = req_q;
        cnt_load = 1'b0;
        cnt_val  = CNT_W'(HOLD_CYCLES - 1);
        unique case (state_q)
            SCR1_RST_SEQ_IDLE: begin
                req_d = '1;
                if (accept) begin
                    req_d   = '0;
                    state_d = SCR1_RST_SEQ_ASSERT;
                end
            end
            SCR1_RST_SEQ_ASSERT: begin
                if (rst_status_n == '0) begin
                    cnt_load = 1'b1;
                    state_d  = SCR1_RST_SEQ_HOLD_ST;
                end else if (tmo_zero) begin
                    state_d = SCR1_RST_SEQ_ERROR;
                end
            end
            SCR1_RST_SEQ_HOLD_ST: begin
                if (cnt_zero) begin
                    req_d[0] = 1'b1;
                    idx_d    = '0;
                    state_d  = SCR1_RST_SEQ_RELEASE;
                end
            end
            SCR1_RST_SEQ_RELEASE: begin
                if (rst_status_n[idx_q]) begin
                    if (last) begin
                        state_d = SCR1_RST_SEQ_DONE;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(GAP_CYCLES);
                        state_d  = SCR1_RST_SEQ_GAP_ST;
                    end
                end else if (tmo_zero) begin
                    req_d   = '0;
                    state_d = SCR1_RST_SEQ_ERROR;
                end
            end
            SCR1_RST_SEQ_GAP_ST: begin
                if (cnt_zero) begin
                    idx_d   = idx_q + IDX_W'(1);
                    req_d   = req_q | (DOMAINS'(1) << idx_d);
                    state_d = SCR1_RST_SEQ_RELEASE;
                end
            end
            SCR1_RST_SEQ_DONE: begin
                state_d = SCR1_RST_SEQ_IDLE;
            end
            SCR1_RST_SEQ_ERROR: begin
                req_d = '0;
                if (accept) begin
                    state_d = SCR1_RST_SEQ_ASSERT;
                end
            end
            default: begin
                state_d = SCR1_RST_SEQ_IDLE;
            end
        endcase
    end

    // Handshake/status flags are decoded from the next state and registered
    always_comb begin
        rdy_d  = (state_d == SCR1_RST_SEQ_IDLE) ||
                 (state_d == SCR1_RST_SEQ_ERROR);
        busy_d = !rdy_d;
        done_d = (state_d == SCR1_RST_SEQ_DONE);
    end

    assign sw_rst_ready = rdy_q;
    assign rst_req_n    = req_q;
    assign seq_busy     = busy_q;
    assign seq_done     = done_q;

`ifdef SCR1_RST_SEQ_TIMEOUT_EN
    localparam int TMO_W = scr1_rst_seq_idx_w(TIMEOUT_CYCLES);

    logic             tmo_load;
    logic             tmo_dec;
    logic             err_q;
    logic [IDX_W-1:0] edom_q;
    logic [IDX_W-1:0] hi_idx;

    assign tmo_load = (state_d != state_q);
    assign tmo_dec  = (state_q == SCR1_RST_SEQ_ASSERT) ||
                      (state_q == SCR1_RST_SEQ_RELEASE);

    scr1_rst_seq_cnt #(
        .W       (TMO_W),
        .RST_VAL (TMO_W'(TIMEOUT_CYCLES - 1))
    ) u_tmo_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmo_load),
        .val_i  (TMO_W'(TIMEOUT_CYCLES - 1)),
        .dec_i  (tmo_dec),
        .zero_o (tmo_zero)
    );

    always_comb begin
        hi_idx = '0;
        for (int i = DOMAINS - 1; i >= 0; i--) begin
            if (rst_status_n[i]) begin
                hi_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            edom_q <= '0;
        end else if ((state_d == SCR1_RST_SEQ_ERROR) &&
                     (state_q != SCR1_RST_SEQ_ERROR)) begin
            err_q  <= 1'b1;
            edom_q <= (state_q == SCR1_RST_SEQ_ASSERT) ? hi_idx : idx_q;
        end else if (accept) begin
            err_q  <= 1'b0;
            edom_q <= '0;
        end
    end

    assign seq_err    = err_q;
    assign err_domain = edom_q;
`else
    assign tmo_zero   = 1'b0;
    assign seq_err    = 1'b0;
    assign err_domain = '0;
`endif

endmodule
